// File: rtl/imem_loader.sv
// Byte-stream program loader: frames a little-endian word count plus words into IMEM debug writes.
// Optional read-back check after every write is enabled by defining IMEM_LOADER_VERIFY_EN.
module imem_loader #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_in_valid,
   input  logic [7:0]  i_in_data,
   output logic        o_in_ready,
   output logic        o_debug_en,
   output logic        o_debug_write_en,
   output logic [31:0] o_debug_addr,
   output logic [31:0] o_debug_data_in,
   input  logic [31:0] i_debug_data_out,
   output logic        o_busy,
   output logic        o_core_hold,
   output logic        o_done,
   output logic        o_error,
   output logic [15:0] o_words_written
);

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StData,
      StWrite,
      StVerify,
      StDone,
      StError
   } state_e;

   state_e      r_state;
   state_e      w_state_next;
   logic [1:0]  r_byte_idx;
   logic [31:0] r_count;
   logic [31:0] r_word;
   logic [15:0] r_words;
   logic        r_dbg_en;
   logic        r_dbg_we;
   logic [31:0] r_dbg_addr;
   logic [31:0] r_dbg_data;

   logic        w_in_ready;
   logic        w_busy;
   logic        w_start_ok;
   logic        w_accept;
   logic        w_last_byte;
   logic [31:0] w_hdr_full;
   logic [31:0] w_word_full;
   logic        w_last_word;
   logic        w_commit;
   logic        w_dbg_en_d;
   logic        w_dbg_we_d;
   logic [31:0] w_dbg_addr_d;
   logic [31:0] w_dbg_data_d;

   assign w_start_ok  = i_start && !w_busy;
   assign w_accept    = i_in_valid && w_in_ready;
   assign w_last_byte = w_accept && (r_byte_idx == 2'd3);
   assign w_hdr_full  = {i_in_data, r_count[23:0]};
   assign w_word_full = {i_in_data, r_word[23:0]};
   assign w_last_word = ({16'd0, r_words} + 32'd1) == r_count;

`ifdef IMEM_LOADER_VERIFY_EN
   // A word counts as committed only once its read-back matches.
   assign w_commit = (r_state == StVerify) && (i_debug_data_out == r_dbg_data);
`else
   assign w_commit = (r_state == StWrite);
`endif

   // State register and datapath
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_byte_idx <= 2'd0;
         r_count    <= 32'd0;
         r_word     <= 32'd0;
         r_words    <= 16'd0;
         r_dbg_en   <= 1'b0;
         r_dbg_we   <= 1'b0;
         r_dbg_addr <= 32'd0;
         r_dbg_data <= 32'd0;
      end else begin
         r_state    <= w_state_next;
         r_dbg_en   <= w_dbg_en_d;
         r_dbg_we   <= w_dbg_we_d;
         r_dbg_addr <= w_dbg_addr_d;
         r_dbg_data <= w_dbg_data_d;
         if (w_start_ok) begin
            r_byte_idx <= 2'd0;
            r_count    <= 32'd0;
            r_words    <= 16'd0;
         end
         if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_state == StHdr) begin
               r_count[{r_byte_idx, 3'b000} +: 8] <= i_in_data;
            end else begin
               r_word[{r_byte_idx, 3'b000} +: 8] <= i_in_data;
            end
         end
         if (w_commit) begin
            r_words <= r_words + 16'd1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle, StDone, StError: begin
            if (i_start) w_state_next = StHdr;
         end
         StHdr: begin
            if (w_last_byte) begin
               if (w_hdr_full == 32'd0)                 w_state_next = StDone;
               else if (w_hdr_full > 32'(MEM_WORDS))    w_state_next = StError;
               else                                     w_state_next = StData;
            end
         end
         StData: begin
            if (w_last_byte) w_state_next = StWrite;
         end
         StWrite: begin
`ifdef IMEM_LOADER_VERIFY_EN
            w_state_next = StVerify;
`else
            w_state_next = w_last_word ? StDone : StData;
`endif
         end
         StVerify: begin
`ifdef IMEM_LOADER_VERIFY_EN
            if (!w_commit)        w_state_next = StError;
            else if (w_last_word) w_state_next = StDone;
            else                  w_state_next = StData;
`else
            w_state_next = StIdle;
`endif
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs; debug_* are registered from their next-state values
   always_comb begin
      w_in_ready   = (r_state == StHdr) || (r_state == StData);
      w_busy       = w_in_ready || (r_state == StWrite) || (r_state == StVerify);
      w_dbg_en_d   = (w_state_next == StWrite) || (w_state_next == StVerify);
      w_dbg_we_d   = (w_state_next == StWrite);
      w_dbg_addr_d = 32'd0;
      w_dbg_data_d = 32'd0;
      if (w_dbg_en_d) begin
         w_dbg_addr_d = BASE_ADDR + {14'd0, r_words, 2'b00};
         w_dbg_data_d = (r_state == StData) ? w_word_full : r_dbg_data;
      end
   end

   assign o_in_ready       = w_in_ready;
   assign o_busy           = w_busy;
   assign o_core_hold      = w_busy;
   assign o_done           = (r_state == StDone);
   assign o_error          = (r_state == StError);
   assign o_words_written  = r_words;
   assign o_debug_en       = r_dbg_en;
   assign o_debug_write_en = r_dbg_we;
   assign o_debug_addr     = r_dbg_addr;
   assign o_debug_data_in  = r_dbg_data;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames against a word-list model.
module tb_imem_loader;

   localparam int unsigned MEM_WORDS = 1024;
   localparam logic [31:0] BASE      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, in_ready;
   logic [7:0]  in_data;
   logic        dbg_en, dbg_we, busy, hold, done, error;
   logic [31:0] dbg_addr, dbg_din, dbg_dout;
   logic [15:0] words_written;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int dbg_bad = 0;
   int hold_bad = 0;
   bit mon_en = 1'b0;

   logic [31:0] mem [0:MEM_WORDS-1];
   bit          corrupt_en = 1'b0;
   logic [31:0] corrupt_addr = 32'd0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_cyc_q[$];
   logic [31:0] words[$];

   always #5 clk = ~clk;

   imem_loader #(
      .MEM_WORDS(MEM_WORDS),
      .BASE_ADDR(BASE)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_start          (start),
      .i_in_valid       (in_valid),
      .i_in_data        (in_data),
      .o_in_ready       (in_ready),
      .o_debug_en       (dbg_en),
      .o_debug_write_en (dbg_we),
      .o_debug_addr     (dbg_addr),
      .o_debug_data_in  (dbg_din),
      .i_debug_data_out (dbg_dout),
      .o_busy           (busy),
      .o_core_hold      (hold),
      .o_done           (done),
      .o_error          (error),
      .o_words_written  (words_written)
   );

   assign dbg_dout = (corrupt_en && dbg_addr == corrupt_addr) ? 32'hDEAD_BEEF
                                                              : mem[dbg_addr[11:2]];

   always @(posedge clk) cyc++;

   // Memory model and write monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (mon_en) begin
         if (dbg_en && dbg_we) begin
            wr_addr_q.push_back(dbg_addr);
            wr_data_q.push_back(dbg_din);
            wr_cyc_q.push_back(cyc);
            mem[dbg_addr[11:2]] = dbg_din;
         end
         if (!dbg_en && (dbg_we || dbg_addr != 32'd0 || dbg_din != 32'd0)) dbg_bad++;
         if (hold !== busy) hold_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      repeat (gap) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("byte_accept_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || error) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!(done || error)) chk("end_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_nwrites"}, wr_addr_q.size(), words.size());
      for (int i = 0; i < words.size() && i < wr_addr_q.size(); i++) begin
         chk({tag, "_addr"}, wr_addr_q[i], BASE + 32'(4 * i));
         chk({tag, "_data"}, wr_data_q[i], words[i]);
      end
   endtask

   task automatic run_frame(input string tag, input int n, input int maxgap, input bit poke);
      words.delete();
      clear_log();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      pulse_start();
      chk({tag, "_hold_start"}, {31'd0, hold}, 32'd1);
      chk({tag, "_ww_cleared"}, {16'd0, words_written}, 32'd0);
      send_word(32'(n), maxgap);
      for (int i = 0; i < n; i++) begin
         send_word(words[i], maxgap);
         if (poke && i == 0) pulse_start();
      end
      wait_end();
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_error"}, {31'd0, error}, 32'd0);
      chk({tag, "_ww"}, {16'd0, words_written}, 32'(n));
      chk({tag, "_hold_end"}, {31'd0, hold}, 32'd0);
      check_writes(tag);
   endtask

   initial begin
      int nw;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);

      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_dbg_en", {31'd0, dbg_en}, 32'd0);
      chk("rst_ww", {16'd0, words_written}, 32'd0);
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Two-word program, back-to-back bytes
      clear_log();
      words.delete();
      words.push_back(32'h0010_0513);
      words.push_back(32'h0020_0593);
      pulse_start();
      send_word(32'd2, 0);
      chk("dir_hold", {31'd0, hold}, 32'd1);
      send_word(32'h0010_0513, 0);
      send_word(32'h0020_0593, 0);
      wait_end();
      chk("dir_done", {31'd0, done}, 32'd1);
      chk("dir_ww", {16'd0, words_written}, 32'd2);
      chk("dir_hold_end", {31'd0, hold}, 32'd0);
      check_writes("dir");
      if (wr_cyc_q.size() == 2) begin
`ifdef IMEM_LOADER_VERIFY_EN
         chk("dir_word_period", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd6);
`else
         chk("dir_word_period", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd5);
`endif
      end

      // Oversized count
      clear_log();
      pulse_start();
      chk("start_clears_done", {31'd0, done}, 32'd0);
      send_word(32'd1025, 0);
      chk("big_error", {31'd0, error}, 32'd1);
      chk("big_busy", {31'd0, busy}, 32'd0);
      chk("big_in_ready", {31'd0, in_ready}, 32'd0);
      chk("big_nwrites", wr_addr_q.size(), 32'd0);

      // Zero count straight from ERROR
      pulse_start();
      chk("start_clears_error", {31'd0, error}, 32'd0);
      chk("start_busy", {31'd0, busy}, 32'd1);
      send_word(32'd0, 0);
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_ww", {16'd0, words_written}, 32'd0);
      chk("zero_nwrites", wr_addr_q.size(), 32'd0);

      // Ten-cycle stall mid-word
      clear_log();
      words.delete();
      words.push_back($urandom);
      words.push_back($urandom);
      pulse_start();
      send_word(32'd2, 0);
      send_byte(words[0][7:0], 0);
      send_byte(words[0][15:8], 0);
      repeat (10) @(negedge clk);
      chk("stall_no_write", wr_addr_q.size(), 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      send_byte(words[0][23:16], 0);
      send_byte(words[0][31:24], 0);
      send_word(words[1], 0);
      wait_end();
      chk("stall_done", {31'd0, done}, 32'd1);
      check_writes("stall");

      // Reset after three of five words, then a fresh load
      clear_log();
      pulse_start();
      send_word(32'd5, 0);
      for (int i = 0; i < 3; i++) send_word($urandom, 0);
      repeat (3) @(negedge clk);
      chk("abort_nwrites", wr_addr_q.size(), 32'd3);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hold", {31'd0, hold}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_ww", {16'd0, words_written}, 32'd0);
      chk("abort_dbg", {dbg_en, dbg_we, 30'd0} | dbg_addr | dbg_din, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      run_frame("after_abort", 3, 0, 1'b0);

      // Random frames with random byte gaps and stray start pulses
      for (int f = 0; f < 8; f++) begin
         nw = $urandom_range(1, 6);
         run_frame("rand", nw, 3, f[0]);
      end

`ifdef IMEM_LOADER_VERIFY_EN
      // Read-back corruption on the second word
      corrupt_addr = BASE + 32'd4;
      corrupt_en   = 1'b1;
      pulse_start();
      send_word(32'd3, 0);
      send_word($urandom, 0);
      send_word($urandom, 0);
      wait_end();
      chk("verify_error", {31'd0, error}, 32'd1);
      chk("verify_ww", {16'd0, words_written}, 32'd1);
      corrupt_en = 1'b0;
`endif

      chk("dbg_zero_outside_write", 32'(dbg_bad), 32'd0);
      chk("hold_equals_busy", 32'(hold_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream program loader that drives the instruction memory's debug/load port, the writer side of that interface. It accepts a framed byte stream from a host link such as a UART receiver or testbench, assembles little-endian 32-bit words, and writes them to consecutive word addresses. While loading it holds the core in reset and reports done or error status to the host.

Parameters:
MEM_WORDS, 1024, instruction memory depth in 32-bit words; upper bound on the load word count.
BASE_ADDR, 32'h00000000, byte address of the first word written; must be word-aligned.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse that begins a load.
in_valid  input  1  host byte valid.
in_data  input  8  host byte.
in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready at posedge.
debug_en  output  1  to memory debug_en.
debug_write_en  output  1  to memory debug_write_en.
debug_addr  output  32  to memory debug_addr, byte address.
debug_data_in  output  32  to memory debug_data_in.
debug_data_out  input  32  from memory debug_data_out, combinational read; used only with the optional feature.
busy  output  1  load in progress.
core_hold  output  1  holds the core in reset; equals busy.
done  output  1  load completed successfully; sticky.
error  output  1  load failed; sticky.
words_written  output  16  count of words committed in the current or last load.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal counters cleared. Reset mid-load aborts immediately. Already-written words stay in memory.
- Frame format: 4-byte word count N, little-endian uint32, followed by N words of 4 bytes each, little-endian (first byte is bits [7:0]).
- IDLE: in_ready=0. A start pulse moves the FSM to HDR, clears done, error and words_written, and sets busy=1.
- HDR: in_ready=1. Accepts 4 bytes into the count register.
  - On the 4th byte, N=0 goes to DONE.
  - N>MEM_WORDS goes to ERROR.
  - Otherwise the FSM goes to DATA with word index k=0.
- DATA: in_ready=1. Accepts 4 bytes into the assembly register. After the 4th byte, the next state is WRITE.
- WRITE: exactly one cycle.
  - in_ready=0, debug_en=1, debug_write_en=1.
  - debug_addr = BASE_ADDR + 4*k, with 32-bit wrap ignored since it is bounded by MEM_WORDS.
  - debug_data_in = assembled word.
  - The memory commits at the end of this cycle. k and words_written increment.
  - If k+1==N the FSM goes to DONE; otherwise it returns to DATA.
- DONE: busy=0, done=1 until the next start or reset. All debug_* outputs are 0.
- ERROR: busy=0, error=1 until the next start or reset. All debug_* outputs are 0.
- start is ignored while busy. It is accepted from IDLE, DONE or ERROR.
- debug_en, debug_write_en, debug_addr and debug_data_in are 0 in every state except WRITE (and VERIFY with the optional feature). They are registered outputs.
- Throughput: without stalls, one word per 5 cycles (4 byte-accept cycles plus 1 WRITE). in_valid gaps stall the FSM indefinitely with no timeout.
- in_data is sampled only when in_valid && in_ready. Bytes presented outside HDR/DATA are not consumed.

Optional Feature:
IMEM_LOADER_VERIFY_EN
- Defined:
  - WRITE is followed by one VERIFY cycle with debug_en=1, debug_write_en=0, and the same debug_addr.
  - debug_data_out is compared against the written word.
  - A mismatch goes to ERROR, with words_written left excluding the failing word. A match continues as in WRITE (increment, then DONE or DATA).
  - Throughput becomes 6 cycles per word.
- Undefined: there is no VERIFY state, and debug_data_out is ignored.

Test Plan:
- Reset then start; stream 02 00 00 00, 13 05 10 00, 93 05 20 00 -> WRITE cycles at addr 0x0 data 0x00100513 and addr 0x4 data 0x00200593; done=1, words_written=2, core_hold 1 throughout then 0.
- Count header 00 00 00 00 -> DONE right after the 4th byte; no debug_write_en pulse; done=1.
- Count header 01 04 00 00 (1025 > MEM_WORDS) -> error=1, no writes, in_ready=0.
- in_valid deasserted for 10 cycles mid-word -> FSM holds in DATA, no write issued; resuming the stream produces the correct word at the correct address.
- Assert reset after 3 of 5 words -> all outputs 0, IDLE; a new start with a fresh frame loads correctly from BASE_ADDR.
- With IMEM_LOADER_VERIFY_EN, memory model forced to return 0xDEADBEEF on the 2nd word -> error=1, words_written=1.
